sysbus_mem_responder: RTL and testbench
=======================================

Name: sysbus_mem_responder

Overview:
Memory-side end of the Sysbus protocol. It answers line requests issued by the core's fetch/load logic.
- Accepts a request address/tag and acknowledges it.
- Reads: after a programmable latency, streams one 64-byte line back as 8 x 64-bit beats.
- Writes: absorbs 8 data beats into a backing store.
- Stands in for DRAM in simulation, and is the block the core's fetch engine talks to.

Parameters:
- MEM_WORDS, 65536: backing store depth in 64-bit words; power of two.
- LATENCY, 4: idle cycles between read acknowledge and the first response beat; 0 permitted.
- TAG_W, 13: width of reqtag/resptag.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- reqcyc  in  1  request valid (address beat, then write data beats).
- req  in  64  request address, or write data during the data phase.
- reqtag  in  TAG_W  [12] = READ(1)/WRITE(0); [11:8] = type (MEMORY=4'b0001, MMIO=4'b0011); [7:0] = id.
- reqack  out  1  request/data beat accepted.
- respcyc  out  1  response beat valid.
- resp  out  64  response data.
- resptag  out  TAG_W  latched reqtag of the request being answered.
- respack  in  1  initiator accepts the current beat.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: reqack=0, respcyc=0, resp=0, resptag=0.
  - State=IDLE, beat=0, latency counter=0.
  - Backing store contents are untouched.
- States: IDLE, WDATA, WAIT, RESP.
- IDLE:
  - On the first edge with reqcyc=1, latch line=req[63:6] and tag=reqtag, then register reqack=1 for exactly one cycle (the cycle after the sample).
  - reqtag[12]=1 goes to WAIT with counter=LATENCY. reqtag[12]=0 goes to WDATA with beat=0.
  - reqcyc is ignored in every state other than IDLE, except as data in WDATA.
- WDATA:
  - reqack = reqcyc (combinational).
  - Each cycle with reqcyc=1 writes req into word {line, beat} and increments beat.
  - After beat 7 is written, go to IDLE. No response is produced for a write.
  - Bubbles (reqcyc=0) are allowed and hold beat.
- WAIT:
  - Decrement the counter each cycle. At 0, go to RESP with beat=0.
  - LATENCY=0: first beat is valid the cycle after the ack cycle.
- RESP:
  - respcyc=1, resp=mem[{line, beat}], resptag=latched tag.
  - On respack=1, beat increments and the next word is presented the following cycle with no bubble.
  - On respack=0, resp, resptag and beat hold stable.
  - After beat 7 is acked, next cycle has respcyc=0 and state returns to IDLE; a new request may be sampled that same cycle.
- Beat order: always line base upward (offset 0..7). The initiator discards leading words itself; there is no critical-word-first.
- Addressing:
  - Word index = {line, beat} modulo MEM_WORDS (upper bits dropped; wraps silently).
  - req[5:0] is ignored.
- MMIO-type tags are serviced identically to MEMORY.
- Simultaneous events: none are possible. Only one transaction is outstanding at a time, and a request arriving while busy is not acknowledged until the responder returns to IDLE, so the initiator must hold reqcyc.
- Assertions:
  - reqtag stable while reqcyc is held unacked in IDLE.
  - respack never high while respcyc is low.

Decomposition:
- Package sysbus_pkg:
  - READ/WRITE constants, MEMORY/MMIO type constants.
  - TAG_W, BEATS_PER_LINE=8, LINE_BYTES=64.
  - Responder state enum.
- Sub-module sysbus_mem_array:
  - MEM_WORDS x 64.
  - Synchronous write, combinational read.
  - Preloadable via $readmemh for benches.
- The FSM, counters and handshake live in sysbus_mem_responder.

Test Plan:
1. Reset with reqcyc=1 held -> reqack=0, respcyc=0, resp=0 throughout reset; first reqack appears 2 cycles after reset release (1 sample + 1 register).
2. Preload words 0x200..0x207 = 0xA0..0xA7; read req=0x1000, tag {1, 4'b0001, 8'h5}, LATENCY=4, respack tied high -> reqack the cycle after the sample, respcyc high 4 cycles after the ack cycle, resp = 0xA0..0xA7 on 8 consecutive cycles, resptag=0x1105, then respcyc=0.
3. Same read with respack low on beats 2 and 5 for 3 cycles each -> resp holds 0xA2 / 0xA5 during the stalls; exactly 8 beats delivered in total, in order.
4. Write req=0x2040 with data 0x11..0x18 and a one-cycle reqcyc bubble after beat 3, then read 0x2040 -> 8 reqack beats on the data phase; read returns 0x11..0x18.
5. MEM_WORDS=1024: read req=0x12000 (word 0x2400) -> returns contents of word 0x0000..0x0007.
6. Assert reset during RESP beat 3 -> respcyc drops in the same cycle; after release, a read of the same line returns all 8 beats from beat 0.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag field encodings, line geometry and the
// responder state encoding.
package sysbus_pkg;

    localparam int TAG_W          = 13;
    localparam int BEATS_PER_LINE = 8;
    localparam int LINE_BYTES     = 64;
    localparam int TAG_RW_BIT     = 12;

    localparam logic       TAG_READ    = 1'b1;
    localparam logic       TAG_WRITE   = 1'b0;
    localparam logic [3:0] TYPE_MEMORY = 4'b0001;
    localparam logic [3:0] TYPE_MMIO   = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WAIT,
        ST_RESP
    } resp_state_e;

    function automatic logic [TAG_W-1:0] make_tag(logic rw, logic [3:0] kind, logic [7:0] id);
        return {rw, kind, id};
    endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response channel between an initiator (master) and the
// memory-side responder (slave).
interface sysbus_mem_responder_if #(
    parameter int TAG_W = 13
);
    logic             reqcyc;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqack;
    logic             respcyc;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_mem_array.sv
// Backing store: MEM_WORDS x 64-bit, synchronous write and combinational read.
// Contents are not reset; a bench preloads the array through write transactions.
module sysbus_mem_array #(
    parameter int MEM_WORDS = 65536
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [63:0]                  wdata,
    output logic [63:0]                  rdata
);
    logic [63:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: acknowledges one line request at a time,
// absorbs 8 write beats or streams 8 read beats after LATENCY idle cycles.
module sysbus_mem_responder #(
    parameter int MEM_WORDS = 65536,
    parameter int LATENCY   = 4,
    parameter int TAG_W     = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    sysbus_mem_responder_if.slave bus
);
    import sysbus_pkg::*;

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int BEAT_W = $clog2(BEATS_PER_LINE);
    localparam int AW     = $clog2(MEM_WORDS);
    // Only the line bits that survive the modulo-MEM_WORDS wrap are kept.
    localparam int LINE_W = AW - BEAT_W;
    localparam int CNT_W  = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

    resp_state_e       state_q, state_d;
    logic [LINE_W-1:0] line_q,  line_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              ack_q,   ack_d;

    logic              wr_beat;
    logic              resp_active;
    logic [AW-1:0]     word_idx;
    logic [63:0]       rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            tag_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        wr_beat = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.reqcyc) begin
                    line_d = bus.req[OFF_W +: LINE_W];
                    tag_d  = bus.reqtag;
                    ack_d  = 1'b1;
                    beat_d = '0;
                    if (bus.reqtag[TAG_RW_BIT] == TAG_READ) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY);
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                // The first WDATA cycle is the address ack cycle; the initiator
                // is still holding the address there, so it is not data.
                if (!ack_q && bus.reqcyc) begin
                    wr_beat = 1'b1;
                    beat_d  = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.respack) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign word_idx    = {line_q, beat_q};
    assign resp_active = (state_q == ST_RESP);

    assign bus.reqack  = ack_q | wr_beat;
    assign bus.respcyc = resp_active;
    assign bus.resp    = resp_active ? rdata : '0;
    assign bus.resptag = resp_active ? tag_q : '0;

    sysbus_mem_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clk   (clk),
        .we    (wr_beat),
        .addr  (word_idx),
        .wdata (bus.req),
        .rdata (rdata)
    );

    // Initiator obligations on the channel.
    a_reqtag_stable: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_IDLE && bus.reqcyc) |=> $stable(bus.reqtag));

    a_respack_needs_respcyc: assert property (@(posedge clk) disable iff (reset)
        bus.respack |-> bus.respcyc);

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: reset, table-driven line
// transfers, randomized traffic against a line-level memory model, reset abort.
module tb_sysbus_mem_responder;
    import sysbus_pkg::*;

    localparam int MW  = 1024;
    localparam int LAT = 4;

    typedef logic [63:0] line_t [8];
    typedef int          stall_t [8];

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [3:0]  kind;
        logic [7:0]  id;
        logic [63:0] base;
        int          stall_a;
        int          stall_b;
        int          stall_len;
        int          bubble_at;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic ack_en;

    always #5 clk = ~clk;

    sysbus_mem_responder_if #(.TAG_W(TAG_W)) bus();

    assign bus.respack = ack_en & bus.respcyc;

    sysbus_mem_responder #(
        .MEM_WORDS (MW),
        .LATENCY   (LAT),
        .TAG_W     (TAG_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] model [MW];
    logic [63:0] written_q [$];
    vec_t        vecs [9];

    function automatic int widx(logic [63:0] a, int i);
        logic [63:0] w;
        w = ((a >> 6) * 64'd8 + 64'(i)) % 64'(MW);
        return int'(w);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents a request on an idle responder; returns at the first cycle after the ack cycle.
    task automatic addr_phase(logic [63:0] addr, logic [12:0] tag, output bit ok);
        int k;
        ok         = 1'b0;
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = tag;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.reqack) begin
                ok = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        chk("ack_delay", 64'(k), 64'd1);
    endtask

    task automatic write_data(logic [63:0] addr, line_t d, int bubble_at, bit rnd);
        int beat;
        bit bubbled;
        bit bub;
        beat    = 0;
        bubbled = 1'b0;
        for (int k = 0; k < 60 && beat < 8; k++) begin
            bub = 1'b0;
            if (beat == bubble_at && !bubbled) begin
                bub     = 1'b1;
                bubbled = 1'b1;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                bub = 1'b1;
            end
            bus.reqcyc = !bub;
            bus.req    = bub ? {$urandom, $urandom} : d[beat];
            @(negedge clk);
            chk("wr_reqack", 64'(bus.reqack), 64'(!bub));
            chk("wr_no_resp", 64'(bus.respcyc), 64'd0);
            if (!bub) begin
                model[widx(addr, beat)] = d[beat];
                beat++;
            end
            cyc();
        end
        bus.reqcyc = 1'b0;
    endtask

    task automatic write_line(logic [63:0] addr, logic [12:0] tag, line_t d, int bubble_at, bit rnd);
        bit ok;
        addr_phase(addr, tag, ok);
        if (ok) write_data(addr, d, bubble_at, rnd);
        bus.reqcyc = 1'b0;
    endtask

    task automatic read_line(logic [63:0] addr, logic [12:0] tag, line_t exp, stall_t stall, int abort_beat);
        bit ok;
        int wait_n;
        int beat;
        int st;
        addr_phase(addr, tag, ok);
        bus.reqcyc = 1'b0;
        bus.req    = {$urandom, $urandom};
        if (!ok) return;
        beat = 0;
        st   = 0;
        for (wait_n = 0; wait_n < 60; wait_n++) begin
            ack_en = (stall[0] == 0);
            @(negedge clk);
            if (bus.respcyc) break;
            cyc();
        end
        chk("rd_latency", 64'(wait_n), 64'(LAT));
        if (wait_n == 60) begin
            ack_en = 1'b0;
            return;
        end
        for (int k = 0; k < 100 && beat < 8; k++) begin
            chk("rd_respcyc", 64'(bus.respcyc), 64'd1);
            chk($sformatf("rd_data_b%0d", beat), bus.resp, exp[beat]);
            chk("rd_resptag", 64'(bus.resptag), 64'(tag));
            if (beat == abort_beat) begin
                reset = 1'b1;
                #1;
                chk("abort_respcyc", 64'(bus.respcyc), 64'd0);
                chk("abort_resp", bus.resp, 64'd0);
                chk("abort_reqack", 64'(bus.reqack), 64'd0);
                ack_en = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            if (ack_en) begin
                beat++;
                st = 0;
            end else begin
                st++;
            end
            cyc();
            ack_en = (beat < 8) ? (st >= stall[beat]) : 1'b0;
            @(negedge clk);
        end
        chk("rd_end_respcyc", 64'(bus.respcyc), 64'd0);
        chk("rd_beats", 64'(beat), 64'd8);
        ack_en = 1'b0;
        cyc();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t  d;
        line_t  e;
        stall_t s;
        logic [63:0] a;
        logic [12:0] t;

        vecs[0] = '{1'b0, 64'h1000,  TYPE_MEMORY, 8'h05, 64'hA0,   -1, -1, 0, -1};
        vecs[1] = '{1'b0, 64'h1000,  TYPE_MEMORY, 8'h05, 64'hA0,    2,  5, 3, -1};
        vecs[2] = '{1'b1, 64'h2040,  TYPE_MEMORY, 8'h21, 64'h11,   -1, -1, 0,  4};
        vecs[3] = '{1'b0, 64'h2040,  TYPE_MEMORY, 8'h22, 64'h11,   -1, -1, 0, -1};
        vecs[4] = '{1'b1, 64'h0000,  TYPE_MEMORY, 8'h30, 64'h5000, -1, -1, 0, -1};
        vecs[5] = '{1'b0, 64'h12000, TYPE_MEMORY, 8'h31, 64'h5000, -1, -1, 0, -1};
        vecs[6] = '{1'b0, 64'h103F,  TYPE_MMIO,   8'h7E, 64'hA0,    0,  7, 1, -1};
        vecs[7] = '{1'b1, 64'h12040, TYPE_MMIO,   8'h40, 64'h900,  -1, -1, 0, -1};
        vecs[8] = '{1'b0, 64'h2040,  TYPE_MEMORY, 8'h41, 64'h900,  -1, -1, 0, -1};

        // Reset held with a write request already pending.
        reset      = 1'b1;
        ack_en     = 1'b0;
        bus.reqcyc = 1'b1;
        bus.req    = 64'h1000;
        bus.reqtag = make_tag(TAG_WRITE, TYPE_MEMORY, 8'h01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_reqack", 64'(bus.reqack), 64'd0);
            chk("rst_respcyc", 64'(bus.respcyc), 64'd0);
            chk("rst_resp", bus.resp, 64'd0);
            chk("rst_resptag", 64'(bus.resptag), 64'd0);
        end
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rel_reqack_c1", 64'(bus.reqack), 64'd0);
        cyc();
        @(negedge clk);
        chk("rel_reqack_c2", 64'(bus.reqack), 64'd1);
        cyc();
        for (int i = 0; i < 8; i++) d[i] = 64'hA0 + 64'(i);
        write_data(64'h1000, d, -1, 1'b0);

        // Table-driven line transfers.
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < 8; i++) begin
                d[i] = vecs[v].base + 64'(i);
                s[i] = (i == vecs[v].stall_a || i == vecs[v].stall_b) ? vecs[v].stall_len : 0;
            end
            t = make_tag(!vecs[v].wr, vecs[v].kind, vecs[v].id);
            if (vecs[v].wr) write_line(vecs[v].addr, t, d, vecs[v].bubble_at, 1'b0);
            else            read_line(vecs[v].addr, t, d, s, -1);
        end

        // Randomized traffic checked against the line-level model.
        for (int n = 0; n < 40; n++) begin
            t = make_tag(1'b0, ($urandom_range(0, 1) != 0) ? TYPE_MMIO : TYPE_MEMORY, 8'($urandom));
            if (written_q.size() == 0 || $urandom_range(0, 9) < 5) begin
                a = {$urandom, $urandom};
                for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
                write_line(a, t, d, -1, 1'b1);
                written_q.push_back(a);
            end else begin
                a = written_q[$urandom_range(0, written_q.size() - 1)];
                a = a ^ ({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_0000) ^ 64'($urandom_range(0, 63));
                for (int i = 0; i < 8; i++) begin
                    e[i] = model[widx(a, i)];
                    s[i] = $urandom_range(0, 2);
                end
                t[TAG_RW_BIT] = TAG_READ;
                read_line(a, t, e, s, -1);
            end
        end

        // Reset in the middle of a response, then the same line again from beat 0.
        a = written_q[0];
        for (int i = 0; i < 8; i++) begin
            e[i] = model[widx(a, i)];
            s[i] = 0;
        end
        t = make_tag(TAG_READ, TYPE_MEMORY, 8'h66);
        read_line(a, t, e, s, 3);
        read_line(a, t, e, s, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
